// File: rtl/elevator_pkg.sv
// Shared elevator definitions: motor commands, tracker states and fault codes.
package elevator_pkg;
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_STOPPED     = 2'd0,
    ST_MOVING_UP   = 2'd1,
    ST_MOVING_DOWN = 2'd2,
    ST_FAULT       = 2'd3
  } tracker_state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_OVERTRAVEL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT    = 2'd2;
  localparam logic [1:0] FC_ILLEGAL    = 2'd3;
endpackage

// File: rtl/sensor_debounce.sv
// Landing-vane conditioning: 2-flop synchronizer, run-length debounce and
// a single-cycle pulse on each debounced 0->1 transition.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam logic [3:0] LP_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_deb;
  logic       r_deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_deb_q <= r_deb;
      // Count consecutive samples that disagree with the debounced level.
      if (r_sync[1] != r_deb) begin
        if (r_cnt == LP_LAST) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_deb;
  assign o_rise  = r_deb & ~r_deb_q;
endmodule

// File: rtl/floor_position_tracker.sv
// Tracks the car's floor from debounced landing edges and the motor command;
// raises a sticky fault on overtravel, travel timeout or illegal/reversed command.
module floor_position_tracker
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TRAVEL_TIMEOUT  = 255,
  parameter int RESET_FLOOR     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elevator_control,
  input  logic       floor_sensor,
  input  logic       fault_clear,
  output logic [3:0] current_floor,
  output logic       at_landing,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam logic [7:0] LP_TMO      = 8'(TRAVEL_TIMEOUT);
  localparam logic [7:0] LP_TMO_LAST = 8'(TRAVEL_TIMEOUT - 1);

  tracker_state_t r_state;
  logic [3:0]     r_floor;
  logic [7:0]     r_timer;
  logic           r_at_landing;
  logic           r_fault;
  logic [1:0]     r_code;

  logic       w_level;
  logic       w_rise;
  logic       w_up;
  logic [1:0] w_rev_cmd;
  logic       w_at_end;
  logic [3:0] w_next_floor;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (floor_sensor),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_up         = (r_state == ST_MOVING_UP);
  assign w_rev_cmd    = w_up ? CMD_DOWN : CMD_UP;
  assign w_at_end     = w_up ? (r_floor == 4'd15) : (r_floor == 4'd0);
  assign w_next_floor = w_up ? r_floor + 4'd1 : r_floor - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_STOPPED;
      r_floor      <= 4'(RESET_FLOOR);
      r_timer      <= '0;
      r_at_landing <= 1'b0;
      r_fault      <= 1'b0;
      r_code       <= FC_NONE;
    end else begin
      r_at_landing <= w_level;
      case (r_state)
        ST_STOPPED: begin
          case (elevator_control)
            CMD_UP: begin
              r_state <= ST_MOVING_UP;
              r_timer <= '0;
            end
            CMD_DOWN: begin
              r_state <= ST_MOVING_DOWN;
              r_timer <= '0;
            end
            CMD_ILL: begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_code  <= FC_ILLEGAL;
            end
            default: ;
          endcase
        end
        ST_MOVING_UP, ST_MOVING_DOWN: begin
          // Illegal command beats a coincident landing edge; the edge beats timeout.
          if (elevator_control == CMD_ILL || elevator_control == w_rev_cmd) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_code  <= FC_ILLEGAL;
          end else if (w_rise) begin
            if (w_at_end) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_code  <= FC_OVERTRAVEL;
            end else begin
              r_floor <= w_next_floor;
              r_timer <= '0;
              if (elevator_control == CMD_STOP) r_state <= ST_STOPPED;
            end
          end else if (elevator_control == CMD_STOP) begin
            r_state <= ST_STOPPED;
          end else if (r_timer == LP_TMO_LAST) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_code  <= FC_TIMEOUT;
            r_timer <= LP_TMO;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_FAULT: begin
          if (fault_clear && elevator_control == CMD_STOP) begin
            r_state <= ST_STOPPED;
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
          end
        end
        default: r_state <= ST_STOPPED;
      endcase
    end
  end

  assign current_floor = r_floor;
  assign at_landing    = r_at_landing;
  assign fault         = r_fault;
  assign fault_code    = r_code;
endmodule

// File: tb/tb_floor_position_tracker.sv
// Scoreboard bench for floor_position_tracker: directed scenarios plus random traffic
// checked every cycle against a direction/run-length reference model.
module tb_floor_position_tracker;
  localparam int DEB = 4;
  localparam int TMO = 255;
  localparam int RF  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] elevator_control = 2'b00;
  logic       floor_sensor = 1'b0;
  logic       fault_clear = 1'b0;
  logic [3:0] current_floor;
  logic       at_landing;
  logic       fault;
  logic [1:0] fault_code;

  floor_position_tracker #(.DEBOUNCE_CYCLES(DEB), .TRAVEL_TIMEOUT(TMO), .RESET_FLOOR(RF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .elevator_control (elevator_control),
    .floor_sensor     (floor_sensor),
    .fault_clear      (fault_clear),
    .current_floor    (current_floor),
    .at_landing       (at_landing),
    .fault            (fault),
    .fault_code       (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] fl;
    logic       at;
    logic       flt;
    logic [1:0] code;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   g_rstn   = 1'b0;

  // Reference model: travel direction (-1/0/+1), fault flag, moving-cycle count,
  // synchronizer delay line and run length of samples that disagree with the level.
  int m_floor, m_dir, m_mcnt, m_run, m_code;
  bit m_flt, m_deb, m_at;
  bit m_sync[2];

  task automatic model_reset();
    m_floor = RF; m_dir = 0; m_mcnt = 0; m_run = 0; m_code = 0;
    m_flt = 0; m_deb = 0; m_at = 0; m_sync[0] = 0; m_sync[1] = 0;
  endtask

  task automatic model_fault(input int code);
    m_flt = 1; m_code = code; m_dir = 0;
  endtask

  task automatic model_edge(input logic [1:0] c, input bit s, input bit fc, input bit rstn);
    bit rise, smp;
    int cdir, nf;
    if (!rstn) begin
      model_reset();
      return;
    end
    rise = m_deb && !m_at;
    cdir = (c == 2'b01) ? 1 : (c == 2'b10) ? -1 : 0;
    if (m_flt) begin
      if (fc && c == 2'b00) begin m_flt = 0; m_code = 0; end
    end else if (m_dir == 0) begin
      if (c == 2'b11) model_fault(3);
      else if (cdir != 0) begin m_dir = cdir; m_mcnt = 0; end
    end else if (c == 2'b11 || cdir == -m_dir) begin
      model_fault(3);
    end else if (rise) begin
      nf = m_floor + m_dir;
      if (nf < 0 || nf > 15) model_fault(1);
      else begin
        m_floor = nf; m_mcnt = 0;
        if (c == 2'b00) m_dir = 0;
      end
    end else if (c == 2'b00) begin
      m_dir = 0;
    end else begin
      m_mcnt++;
      if (m_mcnt >= TMO) model_fault(2);
    end
    m_at = m_deb;
    smp  = m_sync[1];
    if (smp != m_deb) begin
      m_run++;
      if (m_run >= DEB) begin m_deb = smp; m_run = 0; end
    end else m_run = 0;
    m_sync[1] = m_sync[0];
    m_sync[0] = s;
  endtask

  task automatic step(input logic [1:0] c, input logic s, input logic fc);
    exp_t e;
    @(negedge clk);
    rst_n = g_rstn; elevator_control = c; floor_sensor = s; fault_clear = fc;
    model_edge(c, s, fc, g_rstn);
    e.fl = 4'(m_floor); e.at = m_at; e.flt = m_flt; e.code = 2'(m_code);
    expq.push_back(e);
  endtask

  task automatic pulse(input logic [1:0] c, input int hi, input int lo);
    repeat (hi) step(c, 1'b1, 1'b0);
    repeat (lo) step(c, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: outputs are live every cycle, so every clock edge presents one result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        me = expq.pop_front();
        n_checks++;
        if ({current_floor, at_landing, fault, fault_code} == me) n_pass++;
        else $display("FAIL cycle@%0t: got fl=%0d at=%0b flt=%0b code=%0d expected fl=%0d at=%0b flt=%0b code=%0d",
                      $time, current_floor, at_landing, fault, fault_code, me.fl, me.at, me.flt, me.code);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cmd;
    bit sens, fc;
    int s_left, r;
    model_reset();
    g_rstn = 0;
    repeat (3) step(2'b00, 1'b0, 1'b0);
    g_rstn = 1;
    step(2'b00, 1'b0, 1'b0);
    chk("reset_floor", current_floor, 1);
    chk("reset_fault", fault, 0);
    chk("reset_code", fault_code, 0);
    chk("reset_at_landing", at_landing, 0);

    // Three clean landings going up, then stop.
    step(2'b01, 1'b0, 1'b0);
    repeat (3) pulse(2'b01, 10, 10);
    repeat (3) step(2'b00, 1'b0, 1'b0);
    chk("three_landings_floor", current_floor, 4);
    chk("three_landings_fault", fault, 0);

    // Glitch rejection at floor 5, then exact latency of a 5-cycle pulse.
    pulse(2'b01, 10, 10);
    chk("glitch_setup_floor", current_floor, 5);
    pulse(2'b01, 3, 12);
    chk("glitch_rejected", current_floor, 5);
    repeat (5) step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    chk("latency_edge6_floor", current_floor, 5);
    step(2'b01, 1'b0, 1'b0);
    chk("latency_edge7_floor", current_floor, 6);
    repeat (8) step(2'b01, 1'b0, 1'b0);

    // Climb to 15, then overtravel.
    repeat (9) pulse(2'b01, 6, 8);
    chk("top_floor", current_floor, 15);
    pulse(2'b01, 6, 8);
    chk("overtravel_floor", current_floor, 15);
    chk("overtravel_fault", fault, 1);
    chk("overtravel_code", fault_code, 1);
    repeat (2) step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);
    chk("clear_fault", fault, 0);
    chk("clear_code", fault_code, 0);

    // Down to 3, then time out with no landings.
    step(2'b10, 1'b0, 1'b0);
    repeat (12) pulse(2'b10, 6, 8);
    repeat (2) step(2'b00, 1'b0, 1'b0);
    chk("down_floor", current_floor, 3);
    repeat (255) step(2'b10, 1'b0, 1'b0);
    chk("timeout_not_yet", fault, 0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    chk("timeout_fault", fault, 1);
    chk("timeout_code", fault_code, 2);
    step(2'b01, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b0);
    chk("clear_under_up_ignored", fault, 1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);
    chk("timeout_cleared", fault, 0);

    // Reversal without stop.
    repeat (3) step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    repeat (2) step(2'b00, 1'b0, 1'b0);
    chk("reversal_fault", fault, 1);
    chk("reversal_code", fault_code, 3);
    chk("reversal_floor", current_floor, 3);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);

    // Up to 7, then reset asserted while moving down.
    step(2'b01, 1'b0, 1'b0);
    repeat (4) pulse(2'b01, 6, 8);
    step(2'b00, 1'b0, 1'b0);
    repeat (4) step(2'b10, 1'b0, 1'b0);
    chk("pre_reset_floor", current_floor, 7);
    pulse(2'b10, 6, 0);
    @(posedge clk);
    #3;
    rst_n = 0; g_rstn = 0;
    #1;
    chk("async_reset_floor", current_floor, 1);
    chk("async_reset_fault", fault, 0);
    chk("async_reset_code", fault_code, 0);
    chk("async_reset_at_landing", at_landing, 0);
    model_reset();
    repeat (2) step(2'b00, 1'b0, 1'b0);
    g_rstn = 1;
    repeat (2) step(2'b00, 1'b0, 1'b0);

    // Random traffic.
    cmd = 2'b00; sens = 0; s_left = 4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 15));
        cmd = (r == 0) ? 2'b11 : (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : 2'b10;
      end
      if (m_flt && $urandom_range(0, 7) == 0) cmd = 2'b00;
      if (s_left == 0) begin
        sens = ~sens;
        s_left = int'($urandom_range(1, 12));
      end
      s_left--;
      fc = ($urandom_range(0, 5) == 0);
      g_rstn = ($urandom_range(0, 999) != 0);
      step(cmd, sens, fc);
    end
    g_rstn = 1;
    step(2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
